// File: rtl/sw_prio_encoder.sv
// Switch priority encoder: synchronizes and debounces 8 slide switches, encodes the highest
// set switch onto LEDs and one 7-segment digit, with a button-toggled display hold.
// Optional macro SWENC_MULTIHOT_EN adds a registered multi-hot flag on ledr[6].
module sw_prio_encoder #(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int CNT_W           = 24
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [4:0]  btn,
    input  logic [7:0]  sw,
    output logic [15:0] ledr,
    output logic [7:0]  seg0
);

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    // Active-low 7-segment pattern (dp, g..a) for a valid code; blank when not valid.
    function automatic logic [7:0] seg_pattern(input logic [2:0] code, input logic valid);
        logic [7:0] pat;
        if (valid) begin
            case (code)
                3'd0:    pat = 8'hC0;
                3'd1:    pat = 8'hF9;
                3'd2:    pat = 8'hA4;
                3'd3:    pat = 8'hB0;
                3'd4:    pat = 8'h99;
                3'd5:    pat = 8'h92;
                3'd6:    pat = 8'h82;
                3'd7:    pat = 8'hF8;
                default: pat = 8'hFF;
            endcase
        end else begin
            pat = 8'hFF;
        end
        return pat;
    endfunction

`ifdef SWENC_MULTIHOT_EN
    // True when two or more bits of the vector are set.
    function automatic logic is_multi_hot(input logic [7:0] vec);
        logic [3:0] pop;
        pop = 4'd0;
        for (int i = 0; i < 8; i++) begin
            pop = pop + {3'd0, vec[i]};
        end
        return (pop >= 4'd2);
    endfunction
`endif

    logic [7:0]       sw_meta_r;
    logic [7:0]       sw_sync_r;
    logic [7:0]       cand_r;
    logic [CNT_W-1:0] cnt_r;
    logic [7:0]       stable_r;

    logic             btn_meta_r;
    logic             btn_sync_r;
    logic             btn_prev_r;
    logic             hold_r;
    logic             hold_rise_s;
    logic             upd_en_s;

    logic [2:0]       code_s;
    logic             valid_s;
    logic [7:0]       seg_s;

    logic [2:0]       code_r;
    logic             valid_r;
    logic [7:0]       vec_r;
    logic [7:0]       seg_r;
    logic             multi_r;

    logic             btn_unused_s;
    assign btn_unused_s = ^btn[4:1];

    // Two-flop synchronizer for the switch vector.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sw_meta_r <= 8'h00;
            sw_sync_r <= 8'h00;
        end else begin
            sw_meta_r <= sw;
            sw_sync_r <= sw_meta_r;
        end
    end

    // Whole-vector debounce; any change restarts the count, saturating count commits.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cand_r   <= 8'h00;
            cnt_r    <= '0;
            stable_r <= 8'h00;
        end else if (sw_sync_r != cand_r) begin
            cand_r <= sw_sync_r;
            cnt_r  <= '0;
        end else if (cnt_r == CNT_MAX) begin
            stable_r <= cand_r;
        end else begin
            cnt_r <= cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

    // Hold button synchronizer, edge-detect history and hold toggle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            btn_meta_r <= 1'b0;
            btn_sync_r <= 1'b0;
            btn_prev_r <= 1'b0;
            hold_r     <= 1'b0;
        end else begin
            btn_meta_r <= btn[0];
            btn_sync_r <= btn_meta_r;
            btn_prev_r <= btn_sync_r;
            hold_r     <= hold_r ^ hold_rise_s;
        end
    end

    // Rising edge of the synchronized button; a pending toggle also blocks capture.
    always_comb begin
        hold_rise_s = btn_sync_r & ~btn_prev_r;
        upd_en_s    = ~hold_r & ~hold_rise_s;
    end

    // Priority encoder on the committed vector; bit 7 has top priority.
    always_comb begin
        valid_s = |stable_r;
        casez (stable_r)
            8'b1???????: code_s = 3'd7;
            8'b01??????: code_s = 3'd6;
            8'b001?????: code_s = 3'd5;
            8'b0001????: code_s = 3'd4;
            8'b00001???: code_s = 3'd3;
            8'b000001??: code_s = 3'd2;
            8'b0000001?: code_s = 3'd1;
            8'b00000001: code_s = 3'd0;
            default:     code_s = 3'd0;
        endcase
        seg_s = seg_pattern(code_s, valid_s);
    end

    // Display registers; frozen while hold is active.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            code_r  <= 3'd0;
            valid_r <= 1'b0;
            vec_r   <= 8'h00;
            seg_r   <= 8'hFF;
            multi_r <= 1'b0;
        end else if (upd_en_s) begin
            code_r  <= code_s;
            valid_r <= valid_s;
            vec_r   <= stable_r;
            seg_r   <= seg_s;
`ifdef SWENC_MULTIHOT_EN
            multi_r <= is_multi_hot(stable_r);
`else
            multi_r <= 1'b0;
`endif
        end
    end

    assign ledr = {vec_r, 1'b0, multi_r, hold_r, valid_r, 1'b0, code_r};
    assign seg0 = seg_r;

endmodule

// File: tb/tb_sw_prio_encoder.sv
// Directed self-checking bench for sw_prio_encoder with a short debounce window.
module tb_sw_prio_encoder;

    localparam int DB = 4;

    logic        clk;
    logic        rst;
    logic [4:0]  btn;
    logic [7:0]  sw;
    logic [15:0] ledr;
    logic [7:0]  seg0;

    int n_checks;
    int n_errors;

    sw_prio_encoder #(.DEBOUNCE_CYCLES(DB), .CNT_W(24)) dut (
        .clk  (clk),
        .rst  (rst),
        .btn  (btn),
        .sw   (sw),
        .ledr (ledr),
        .seg0 (seg0)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Wait n rising edges, then move to 1 time unit after the last one.
    task automatic edges(input int n);
        for (int i = 0; i < n; i++) @(posedge clk);
        #1;
    endtask

    logic [7:0] seg_tab [8] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8};
    logic       mh_exp;

    initial begin
        n_checks = 0;
        n_errors = 0;
        rst = 1'b1;
        btn = 5'd0;
        sw  = 8'h00;
        #2;
        check_eq("reset_ledr", ledr, 16'h0000);
        check_eq("reset_seg", {8'h00, seg0}, 16'h00FF);
        edges(3);
        @(negedge clk);
        rst = 1'b0;
        edges(12);
        check_eq("idle_ledr", ledr, 16'h0000);

        // Short glitch must never reach the outputs.
        @(negedge clk);
        sw = 8'h01;
        edges(3);
        @(negedge clk);
        sw = 8'h00;
        for (int i = 0; i < 15; i++) begin
            edges(1);
            check_eq("glitch_ledr", ledr, 16'h0000);
            check_eq("glitch_seg", {8'h00, seg0}, 16'h00FF);
        end

        // Commit latency: unchanged through edge 7, new value after edge 8.
        @(negedge clk);
        sw = 8'h24;
        edges(7);
        check_eq("lat_e7_ledr", ledr, 16'h0000);
        check_eq("lat_e7_seg", {8'h00, seg0}, 16'h00FF);
        edges(1);
        check_eq("lat_e8_ledr", ledr, 16'h2415);
        check_eq("lat_e8_seg", {8'h00, seg0}, 16'h0092);

        // Walking one across all switches.
        for (int b = 0; b < 8; b++) begin
            @(negedge clk);
            sw = 8'h01 << b;
            edges(10);
            check_eq("walk_ledr", ledr, {8'h01 << b, 5'b00010, 3'(b)});
            check_eq("walk_seg", {8'h00, seg0}, {8'h00, seg_tab[b]});
        end

        // Hold freezes 8'h80 while switches move to 8'h02.
        @(negedge clk);
        btn = 5'b00001;
        edges(10);
        @(negedge clk);
        btn = 5'b00000;
        sw  = 8'h02;
        edges(20);
        check_eq("hold_ledr", ledr, 16'h8037);
        check_eq("hold_seg", {8'h00, seg0}, 16'h00F8);
        @(negedge clk);
        btn = 5'b00001;
        edges(3);
        check_eq("rel_e3_ledr", ledr, 16'h8017);
        edges(1);
        check_eq("rel_e4_ledr", ledr, 16'h0211);
        check_eq("rel_e4_seg", {8'h00, seg0}, 16'h00F9);
        @(negedge clk);
        btn = 5'b00000;
        edges(10);
        check_eq("rel_stay_ledr", ledr, 16'h0211);

        // Multi-hot flag.
`ifdef SWENC_MULTIHOT_EN
        mh_exp = 1'b1;
`else
        mh_exp = 1'b0;
`endif
        @(negedge clk);
        sw = 8'h81;
        edges(10);
        check_eq("mh81_ledr", ledr, {8'h81, 1'b0, mh_exp, 6'b010111});
        check_eq("mh81_seg", {8'h00, seg0}, 16'h00F8);
        @(negedge clk);
        sw = 8'h08;
        edges(10);
        check_eq("mh08_ledr", ledr, 16'h0813);
        check_eq("mh08_seg", {8'h00, seg0}, 16'h00B0);

        // Asynchronous reset mid-count, then a full-length restart.
        @(negedge clk);
        sw = 8'h10;
        edges(2);
        #2;
        rst = 1'b1;
        #1;
        check_eq("arst_ledr", ledr, 16'h0000);
        check_eq("arst_seg", {8'h00, seg0}, 16'h00FF);
        edges(2);
        @(negedge clk);
        rst = 1'b0;
        edges(7);
        check_eq("rst_e7_ledr", ledr, 16'h0000);
        edges(1);
        check_eq("rst_e8_ledr", ledr, 16'h1014);
        check_eq("rst_e8_seg", {8'h00, seg0}, 16'h0099);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
